// File: rtl/core_run_ctrl.sv
// core_run_ctrl: button-driven halt/step/run/burst sequencer for the core's step strobe, with PC breakpoint.
// Define CORE_RUN_CTRL_BP_FLAG_EN to add the sticky bp_hit status output.
module core_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 1,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_step,
    input  logic            btn_run,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      burst_len,
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
    output logic            bp_hit,
`endif
    output logic            step,
    output logic            halted,
    output logic [1:0]      state,
    output logic [31:0]     step_count
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

    typedef enum logic [1:0] {HALT = 2'd0, STEP = 2'd1, RUN = 2'd2, BURST = 2'd3} state_t;

    state_t        st;
    logic [1:0]    btn, s1, s2, db, db_q, press;
    logic [CW-1:0] cnt [2];
    logic          run_p, step_p, bp_skip, hit, slot;
    logic [DW-1:0] div_cnt;
    logic [7:0]    remaining;

    assign btn = {btn_run, btn_step};

    // Bit 0 is the step button, bit 1 the run button
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int b = 0; b < 2; b++) cnt[b] <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            for (int b = 0; b < 2; b++) begin
                if (s2[b] == db[b]) cnt[b] <= '0;
                else if (cnt[b] == DB_MAX) begin
                    db[b]  <= s2[b];
                    cnt[b] <= '0;
                end else cnt[b] <= cnt[b] + 1'b1;
            end
        end
    end

    assign press  = db & ~db_q;
    assign step_p = press[0];
    assign run_p  = press[1];

    // bp_skip lets a resume execute the instruction that caused the halt
    assign hit    = bp_en && pc == bp_addr && !bp_skip;
    assign slot   = (st == RUN || st == BURST) && div_cnt == '0 && !run_p;
    assign step   = !reset && (st == STEP || (slot && !hit));
    assign halted = st == HALT;
    assign state  = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= HALT;
            bp_skip    <= 1'b0;
            div_cnt    <= '0;
            remaining  <= '0;
            step_count <= '0;
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
            bp_hit     <= 1'b0;
`endif
        end else begin
            if (step) step_count <= step_count + 32'd1;
            div_cnt <= div_cnt == DIV_MAX ? '0 : div_cnt + 1'b1;
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
            if (run_p || step_p) bp_hit <= 1'b0;
            else if (slot && hit) bp_hit <= 1'b1;
`endif
            case (st)
                HALT: begin
                    div_cnt <= '0;
                    if (run_p) begin
                        st      <= RUN;
                        bp_skip <= 1'b1;
                    end else if (step_p) begin
                        st        <= burst_len == 8'd0 ? STEP : BURST;
                        remaining <= burst_len;
                        bp_skip   <= 1'b1;
                    end
                end
                STEP: st <= HALT;
                default: begin
                    if (run_p) st <= HALT;
                    else if (slot) begin
                        if (hit) st <= HALT;
                        else begin
                            bp_skip <= 1'b0;
                            if (st == BURST) begin
                                remaining <= remaining - 8'd1;
                                if (remaining == 8'd1) st <= HALT;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed bench for core_run_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3.
// The bench models the core as a PC that advances by 4 per step and wraps at 0x20.
module tb_core_run_ctrl;
    logic        clk = 1'b0, reset = 1'b1, btn_step = 1'b0, btn_run = 1'b0, bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc = '0;
    logic [7:0]  burst_len = '0;
    logic        step, halted;
    logic [1:0]  state;
    logic [31:0] step_count;
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
    logic        bp_hit;
`endif
    logic        pc_clr = 1'b1;
    int          cyc = 0, last = 0, nstep = 0, total = 0, bad = 0, first_step = 0;
    bit          gap_bad = 1'b0;

    typedef struct {
        bit          run;
        logic [7:0]  blen;
        bit          bpen;
        logic [31:0] bpa;
        int          exp_n;
        logic [1:0]  exp_st;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    core_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .PC_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .btn_step(btn_step),
        .btn_run(btn_run),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc(pc),
        .burst_len(burst_len),
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
        .bp_hit(bp_hit),
`endif
        .step(step),
        .halted(halted),
        .state(state),
        .step_count(step_count)
    );

    // Core model plus step-spacing monitor: steps within one run must be 3 cycles apart
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_clr) begin
            pc      <= '0;
            nstep   <= 0;
            last    <= 0;
            gap_bad <= 1'b0;
        end else if (step) begin
            pc    <= (pc + 32'd4) & 32'h1f;
            nstep <= nstep + 1;
            last  <= cyc;
            if (nstep != 0 && cyc - last != 3 && cyc - last < 8) gap_bad <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Iteration i sets the buttons before posedge i and samples step after it
    task automatic drive(input int n, input int r_lo, input int r_hi, input int s_lo, input int s_hi);
        first_step = 0;
        for (int i = 1; i <= n; i++) begin
            btn_run  = i >= r_lo && i <= r_hi;
            btn_step = i >= s_lo && i <= s_hi;
            @(negedge clk);
            if (step && first_step == 0) first_step = i;
        end
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pc_clr   = 1'b1;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        pc_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{run: 1'b0, blen: 8'd0, bpen: 1'b0, bpa: 32'h0,  exp_n: 1,  exp_st: 2'd0};
        vecs[1] = '{run: 1'b0, blen: 8'd5, bpen: 1'b0, bpa: 32'h0,  exp_n: 5,  exp_st: 2'd0};
        vecs[2] = '{run: 1'b0, blen: 8'd1, bpen: 1'b0, bpa: 32'h0,  exp_n: 1,  exp_st: 2'd0};
        vecs[3] = '{run: 1'b0, blen: 8'd4, bpen: 1'b1, bpa: 32'h8,  exp_n: 2,  exp_st: 2'd0};
        vecs[4] = '{run: 1'b0, blen: 8'd3, bpen: 1'b1, bpa: 32'h0,  exp_n: 3,  exp_st: 2'd0};
        vecs[5] = '{run: 1'b1, blen: 8'd0, bpen: 1'b1, bpa: 32'h10, exp_n: 4,  exp_st: 2'd0};
        vecs[6] = '{run: 1'b1, blen: 8'd7, bpen: 1'b1, bpa: 32'h7,  exp_n: -1, exp_st: 2'd2};
        vecs[7] = '{run: 1'b0, blen: 8'd2, bpen: 1'b0, bpa: 32'h4,  exp_n: 2,  exp_st: 2'd0};

        @(negedge clk);
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_count", step_count, 32'd0);
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
`endif

        // Single step: press at edge 6 (2 sync + 4 debounce), STEP occupies the cycle after edge 7
        burst_len = 8'd0;
        drive(30, 0, 0, 1, 10);
        chk("step_latency", first_step, 32'd7);
        chk("step_once", nstep, 32'd1);
        chk("step_count1", step_count, 32'd1);
        chk("step_state", 32'(state), 32'd0);
        for (int i = 0; i < 24; i++) begin
            btn_step = i[1];
            @(negedge clk);
        end
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
        chk("chatter_steps", nstep, 32'd1);
        chk("chatter_count", step_count, 32'd1);

        // RUN: steps at edges 7,10,..,31; second press lands at edge 32, halting before the 10th slot
        do_reset();
        drive(26, 1, 8, 0, 0);
        chk("run_first_step", first_step, 32'd7);
        drive(24, 1, 8, 0, 0);
        chk("run_steps", nstep, 32'd9);
        chk("run_count", step_count, 32'd9);
        chk("run_halted", 32'(halted), 32'd1);
        chk("run_state", 32'(state), 32'd0);
        chk("run_gap", 32'(gap_bad), 32'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            bp_en     = vecs[v].bpen;
            bp_addr   = vecs[v].bpa;
            burst_len = vecs[v].blen;
            drive(40, vecs[v].run ? 1 : 0, vecs[v].run ? 8 : 0, vecs[v].run ? 0 : 1, vecs[v].run ? 0 : 8);
            if (vecs[v].exp_n >= 0) chk($sformatf("vec%0d_steps", v), nstep, vecs[v].exp_n);
            chk($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].exp_st));
            chk($sformatf("vec%0d_halted", v), 32'(halted), 32'(vecs[v].exp_st == 2'd0));
            chk($sformatf("vec%0d_count", v), step_count, nstep);
            chk($sformatf("vec%0d_gap", v), 32'(gap_bad), 32'd0);
        end
        bp_en = 1'b0;

        // Breakpoint resume: halt at 0x10, resume steps 0x10 first, wraps round and halts at 0x10 again
        do_reset();
        bp_en     = 1'b1;
        bp_addr   = 32'h10;
        burst_len = 8'd0;
        drive(30, 1, 8, 0, 0);
        chk("bp_steps", nstep, 32'd4);
        chk("bp_pc", pc, 32'h10);
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_step_low", 32'(step), 32'd0);
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
`endif
        drive(10, 1, 8, 0, 0);
        chk("bp_resume_state", 32'(state), 32'd2);
        chk("bp_resume_first", first_step, 32'd7);
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
        chk("bp_hit_clear", 32'(bp_hit), 32'd0);
`endif
        drive(40, 0, 0, 0, 0);
        chk("bp_revisit_steps", nstep, 32'd12);
        chk("bp_revisit_pc", pc, 32'h10);
        chk("bp_revisit_state", 32'(state), 32'd0);
        chk("bp_revisit_count", step_count, 32'd12);
`ifdef CORE_RUN_CTRL_BP_FLAG_EN
        chk("bp_hit_again", 32'(bp_hit), 32'd1);
`endif
        bp_en = 1'b0;

        // Simultaneous presses: run wins
        do_reset();
        burst_len = 8'd0;
        drive(10, 1, 8, 1, 8);
        chk("simul_state", 32'(state), 32'd2);

        // Reset during the third burst slot (remaining=3)
        do_reset();
        burst_len = 8'd5;
        drive(13, 0, 0, 1, 8);
        chk("burst_slot3_step", 32'(step), 32'd1);
        chk("burst_pre_count", step_count, 32'd2);
        reset = 1'b1;
        #1;
        chk("step_in_reset", 32'(step), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_step", 32'(step), 32'd0);
        chk("mid_rst_count", step_count, 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
